// File: rtl/static_bus_ctrl_pkg.sv
// Shared state type and sizing helpers for the static bus controller.
package static_bus_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int owner_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int cnt_width(input int hold_cycles);
    return (hold_cycles > 0) ? $clog2(hold_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/static_bus_ctrl_arb.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping upward.
// Zero latency; no grant while en is low.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic           hit;
  int             sel;

  always_comb begin
    // Rotate so bit j of the lower half is requester (ptr + j) mod N.
    dbl = {req, req} >> ptr;
    hit = 1'b0;
    sel = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (dbl[j]) begin
        hit = 1'b1;
        sel = j;
      end
    end
    sel = sel + int'(ptr);
    if (sel >= N) sel = sel - N;
    any       = hit & en;
    grant_idx = any ? IW'(sel) : '0;
    grant     = any ? (N'(1) << sel) : '0;
  end

endmodule

// File: rtl/static_bus_ctrl.sv
// Round-robin loader for a quasi-static CDC bus word; ack pulses HOLD_CYCLES+1 edges after grant (2 on skip).
// Requesters hold req and data until ack; others wait in IDLE, and no grant is made in an ack cycle.
module static_bus_ctrl
  import static_bus_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int NUM_REQ     = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int SKIP_SAME   = 1,
  localparam int OW = owner_width(NUM_REQ),
  localparam int CW = cnt_width(HOLD_CYCLES)
) (
  input  logic                          in_clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          busy,
  output logic [OW-1:0]                 owner,
  output logic [DATA_WIDTH-1:0]         bus_data
);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [OW-1:0]      rr_ptr;
  logic               arb_en;
  logic [NUM_REQ-1:0] gnt;
  logic [OW-1:0]      gnt_idx;
  logic               gnt_any;
  logic [DATA_WIDTH-1:0] win_word;
  logic               same_word;

  // The ack guard keeps a just-served requester, whose req is still high, from winning again.
  assign arb_en = (state == IDLE) && (ack == '0);

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (OW)
  ) u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .en        (arb_en),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .any       (gnt_any)
  );

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_word = win_word | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt[i]}});
    end
  end

  assign same_word = (win_word == bus_data);

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bus_data <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      owner    <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            bus_data <= win_word;
            owner    <= gnt_idx;
            busy     <= 1'b1;
            state    <= HOLD;
            // An unchanged word cannot glitch the far side, so one hold cycle suffices.
            cnt      <= ((SKIP_SAME != 0) && same_word) ? '0 : CW'(HOLD_CYCLES - 1);
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            ack    <= NUM_REQ'(1) << owner;
            rr_ptr <= (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
